mmio_ctrl: RTL and testbench
============================

# mmio_ctrl

Parametrised memory-mapped I/O controller on the processor's MEM stage. It generalises the fixed HEX/LEDR/KEY decode into a device block with:
- debounced key and switch inputs, each with ready/overrun status;
- a programmable interval timer;
- width-parametrised HEX and LEDR output registers.

The MEM stage presents every data access. The block claims addresses in its window and returns read data combinationally. Unclaimed accesses fall through to D-MEM.

## Interface
Parameters:
- DBITS, 32, data/address width
- KEYBITS, 4, key input count
- SWBITS, 10, switch input count
- HEXBITS, 24, HEX register width
- LEDRBITS, 10, LEDR register width
- HEXRESET, 24'hFEDEAD, HEX reset value
- DEBCYCLES, 100000, consecutive stable cycles required before a debounced input updates
- TICKCYCLES, 50000, clocks per timer tick
- ADDRHEX/ADDRLEDR/ADDRKEY/ADDRSW/ADDRTIMER, FFFFF000/FFFFF020/FFFFF080/FFFFF090/FFFFF100, device base addresses

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- addr  in  DBITS  MEM-stage byte address
- rd_en  in  1  load in MEM this cycle
- wr_en  in  1  store in MEM this cycle
- wr_data  in  DBITS  store data
- rd_data  out  DBITS  combinational read data; 0 when not hit
- io_hit  out  1  addr matches a mapped register (combinational)
- key_n  in  KEYBITS  raw keys, active-low
- sw  in  SWBITS  raw switches
- hex  out  HEXBITS  HEX display value
- ledr  out  LEDRBITS  LED value

## Operation
- Register map, as offsets from each base:
  - HEX +0 (R/W)
  - LEDR +0 (R/W)
  - KDATA = ADDRKEY+0 (R)
  - KCTRL = ADDRKEY+4 (R/W0C)
  - SDATA = ADDRSW+0 (R)
  - SCTRL = ADDRSW+4 (R/W0C)
  - TCNT = ADDRTIMER+0 (R/W)
  - TLIM = ADDRTIMER+4 (R/W)
  - TCTL = ADDRTIMER+8 (R/W0C)
- Reads are zero-extended to DBITS. Writes to read-only registers and unmapped addresses are ignored.
- Input conditioning:
  - keys are inverted to active-high;
  - keys and switches each pass a 2-flop synchronizer, then a debounce counter;
  - a debounced bit updates only after its synchronized value differs from the debounced value for DEBCYCLES consecutive cycles;
  - any mismatch gap restarts the count.
- KDATA/SDATA = debounced value.
- Status register layout (KCTRL, SCTRL, TCTL): bit0 ready, bit2 overrun, all other bits read 0.
  - An event sets ready. If ready is already 1 at the event, overrun is also set.
  - KEY/SW event: any change of the debounced vector.
  - Status write: bits 0 and 2 are cleared where wr_data is 0; writing 1 has no effect.
  - Clearing ready on read: a rd_en read of KDATA clears KCTRL.ready; a rd_en read of SDATA clears SCTRL.ready.
- Timer:
  - the prescaler counts 0..TICKCYCLES-1 and emits a tick on wrap;
  - on a tick with TLIM≠0: if TCNT==TLIM-1, TCNT←0 and a timer event is raised; otherwise TCNT←TCNT+1;
  - with TLIM==0, TCNT increments freely, wraps at 2^DBITS, and raises no events;
  - a write to TCNT loads the counter and clears the prescaler;
  - a write to TLIM stores the limit, clears TCNT, and clears the prescaler.
- HEX/LEDR take wr_data[HEXBITS-1:0] / wr_data[LEDRBITS-1:0] on a store.

## Timing
- rd_data and io_hit: same-cycle combinational from addr and register state.
- All register updates occur at posedge clk. A store is visible to reads in the next cycle.
- Simultaneous events on the same edge:
  - read-clear of ready and a new event: ready stays 1; overrun is not set.
  - status write-clear and a new event: the event wins (ready=1), and overrun is set only if ready was 1 before the edge.
  - TCNT write and a tick: the write wins, and no event is raised.
- Reset values:
  - hex=HEXRESET, ledr=0;
  - TCNT=0, TLIM=0, all status bits 0;
  - debounced key value 0 (released), debounced switch value 0;
  - synchronizers, debounce counters and prescaler 0.
- Reset asserted mid-count abandons the count immediately.
- Latency from a raw input change to KDATA/SDATA: 2 + DEBCYCLES cycles.

## Structure
- Shared package holds:
  - register offsets and default base addresses;
  - status bit positions (READY=0, OVERRUN=2);
  - the status-register-update function (event / read-clear / write-clear priority).
- Sub-module `input_debounce`, parameterised by width and DEBCYCLES (synchronizer plus per-bit counter), instanced once for keys and once for switches.

## Test plan
Run with DEBCYCLES=4 and TICKCYCLES=3.
- After reset, read HEX and status registers → HEX=0x00FEDEAD, LEDR=0, KCTRL/SCTRL/TCTL=0, io_hit=1 for each mapped address, io_hit=0 and rd_data=0 for 0xFFFFF0F0.
- key_n: 1111→1110, held 6 cycles → KDATA=0x1 at cycle 6, KCTRL=0x1. Then read KDATA with rd_en → KCTRL=0x0.
- Switch glitches, then a clean change:
  - glitch sw=0x001 for 3 cycles, back to 0 → SDATA unchanged;
  - then hold 0x3FF → SDATA=0x3FF and SCTRL=0x1;
  - then change to 0x000 without reading → SCTRL=0x5;
  - then write SCTRL=0 → SCTRL=0.
- Write TLIM=3 → TCNT sequence 0,1,2,0 on ticks every 3 cycles, TCTL=1 after the first wrap and TCTL=5 after the second. A TCNT write coinciding with a tick loads the written value with no event.
- Store 0x12345678 to LEDR → ledr=0x278 next cycle. A same-cycle load of LEDR returns the old value.
- Assert reset mid-debounce and with timer running → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/mmio_ctrl_pkg.sv
// Shared definitions for the MEM-stage I/O block: default addresses, register offsets,
// register selectors and the ready/overrun status update rule.
package mmio_ctrl_pkg;

    localparam logic [31:0] DEF_ADDRHEX   = 32'hFFFF_F000;
    localparam logic [31:0] DEF_ADDRLEDR  = 32'hFFFF_F020;
    localparam logic [31:0] DEF_ADDRKEY   = 32'hFFFF_F080;
    localparam logic [31:0] DEF_ADDRSW    = 32'hFFFF_F090;
    localparam logic [31:0] DEF_ADDRTIMER = 32'hFFFF_F100;

    localparam int OFS_DATA = 0;
    localparam int OFS_CTRL = 4;
    localparam int OFS_TCNT = 0;
    localparam int OFS_TLIM = 4;
    localparam int OFS_TCTL = 8;

    localparam int STAT_READY   = 0;
    localparam int STAT_OVERRUN = 2;

    typedef enum logic [3:0] {
        REG_NONE,
        REG_HEX,
        REG_LEDR,
        REG_KDATA,
        REG_KCTRL,
        REG_SDATA,
        REG_SCTRL,
        REG_TCNT,
        REG_TLIM,
        REG_TCTL
    } reg_sel_t;

    typedef struct packed {
        logic overrun;
        logic ready;
    } status_t;

    // An event always wins over clears; overrun only flags data lost without being read.
    function automatic status_t status_next(
        input status_t cur,
        input logic    evt,
        input logic    rd_clr,
        input logic    wr,
        input logic    wr_ready,
        input logic    wr_overrun
    );
        status_t nxt;
        nxt = cur;
        if (rd_clr)
            nxt.ready = 1'b0;
        if (wr && !wr_ready)
            nxt.ready = 1'b0;
        if (wr && !wr_overrun)
            nxt.overrun = 1'b0;
        if (evt) begin
            nxt.ready = 1'b1;
            if (cur.ready && !rd_clr)
                nxt.overrun = 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mmio_ctrl_if.sv
// MEM-stage data access bus as seen by the I/O block: the pipeline drives the access,
// the device block answers with combinational read data and a hit flag.
interface mmio_ctrl_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] addr;
    logic             rd_en;
    logic             wr_en;
    logic [DBITS-1:0] wr_data;
    logic [DBITS-1:0] rd_data;
    logic             io_hit;

    modport master (
        output addr, rd_en, wr_en, wr_data,
        input  rd_data, io_hit
    );

    modport slave (
        input  addr, rd_en, wr_en, wr_data,
        output rd_data, io_hit
    );
endinterface

// File: rtl/mmio_ctrl_input_debounce.sv
// Two-flop synchronizer followed by a per-bit debounce counter; `change` is high on the
// cycle whose closing edge updates the debounced vector.
module input_debounce #(
    parameter int WIDTH     = 4,
    parameter int DEBCYCLES = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] deb,
    output logic             change
);
    localparam int CW = (DEBCYCLES > 1) ? $clog2(DEBCYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBCYCLES - 1);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [WIDTH-1:0] flip;
    logic [CW-1:0]    cnt [WIDTH];

    always_comb begin
        flip = '0;
        for (int i = 0; i < WIDTH; i++)
            flip[i] = (sync_p1[i] != deb[i]) && (cnt[i] == CNT_LAST);
    end

    assign change = |flip;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            deb     <= '0;
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            deb     <= deb ^ flip;
            // A matching sample anywhere in the window restarts the count.
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_p1[i] == deb[i] || flip[i])
                    cnt[i] <= '0;
                else
                    cnt[i] <= cnt[i] + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mmio_ctrl.sv
// Memory-mapped device block on the MEM stage: HEX/LEDR outputs, debounced keys and
// switches with ready/overrun status, and a programmable interval timer.
module mmio_ctrl
    import mmio_ctrl_pkg::*;
#(
    parameter int                  DBITS      = 32,
    parameter int                  KEYBITS    = 4,
    parameter int                  SWBITS     = 10,
    parameter int                  HEXBITS    = 24,
    parameter int                  LEDRBITS   = 10,
    parameter logic [HEXBITS-1:0]  HEXRESET   = 24'hFEDEAD,
    parameter int                  DEBCYCLES  = 100000,
    parameter int                  TICKCYCLES = 50000,
    parameter logic [DBITS-1:0]    ADDRHEX    = DBITS'(DEF_ADDRHEX),
    parameter logic [DBITS-1:0]    ADDRLEDR   = DBITS'(DEF_ADDRLEDR),
    parameter logic [DBITS-1:0]    ADDRKEY    = DBITS'(DEF_ADDRKEY),
    parameter logic [DBITS-1:0]    ADDRSW     = DBITS'(DEF_ADDRSW),
    parameter logic [DBITS-1:0]    ADDRTIMER  = DBITS'(DEF_ADDRTIMER)
) (
    input  logic                clk,
    input  logic                reset,
    mmio_ctrl_if.slave          bus,
    input  logic [KEYBITS-1:0]  key_n,
    input  logic [SWBITS-1:0]   sw,
    output logic [HEXBITS-1:0]  hex,
    output logic [LEDRBITS-1:0] ledr
);
    localparam logic [DBITS-1:0] A_KDATA = ADDRKEY   + DBITS'(OFS_DATA);
    localparam logic [DBITS-1:0] A_KCTRL = ADDRKEY   + DBITS'(OFS_CTRL);
    localparam logic [DBITS-1:0] A_SDATA = ADDRSW    + DBITS'(OFS_DATA);
    localparam logic [DBITS-1:0] A_SCTRL = ADDRSW    + DBITS'(OFS_CTRL);
    localparam logic [DBITS-1:0] A_TCNT  = ADDRTIMER + DBITS'(OFS_TCNT);
    localparam logic [DBITS-1:0] A_TLIM  = ADDRTIMER + DBITS'(OFS_TLIM);
    localparam logic [DBITS-1:0] A_TCTL  = ADDRTIMER + DBITS'(OFS_TCTL);
    localparam int PW = (TICKCYCLES > 1) ? $clog2(TICKCYCLES) : 1;

    reg_sel_t            sel;
    logic [DBITS-1:0]    rdata;
    logic [HEXBITS-1:0]  hex_q;
    logic [LEDRBITS-1:0] ledr_q;
    logic [KEYBITS-1:0]  key_deb;
    logic [SWBITS-1:0]   sw_deb;
    logic                key_change;
    logic                sw_change;
    status_t             kstat, sstat, tstat;
    logic [PW-1:0]       pre_q;
    logic [DBITS-1:0]    tcnt_q;
    logic [DBITS-1:0]    tlim_q;
    logic                tick;
    logic                t_evt;
    logic                wr_tcnt, wr_tlim;

    input_debounce #(.WIDTH(KEYBITS), .DEBCYCLES(DEBCYCLES)) u_key_deb (
        .clk    (clk),
        .reset  (reset),
        .raw    (~key_n),
        .deb    (key_deb),
        .change (key_change)
    );

    input_debounce #(.WIDTH(SWBITS), .DEBCYCLES(DEBCYCLES)) u_sw_deb (
        .clk    (clk),
        .reset  (reset),
        .raw    (sw),
        .deb    (sw_deb),
        .change (sw_change)
    );

    always_comb begin
        sel = REG_NONE;
        if      (bus.addr == ADDRHEX)  sel = REG_HEX;
        else if (bus.addr == ADDRLEDR) sel = REG_LEDR;
        else if (bus.addr == A_KDATA)  sel = REG_KDATA;
        else if (bus.addr == A_KCTRL)  sel = REG_KCTRL;
        else if (bus.addr == A_SDATA)  sel = REG_SDATA;
        else if (bus.addr == A_SCTRL)  sel = REG_SCTRL;
        else if (bus.addr == A_TCNT)   sel = REG_TCNT;
        else if (bus.addr == A_TLIM)   sel = REG_TLIM;
        else if (bus.addr == A_TCTL)   sel = REG_TCTL;
    end

    function automatic logic [DBITS-1:0] stat_word(input status_t s);
        logic [DBITS-1:0] w;
        w               = '0;
        w[STAT_READY]   = s.ready;
        w[STAT_OVERRUN] = s.overrun;
        return w;
    endfunction

    always_comb begin
        rdata = '0;
        case (sel)
            REG_HEX:   rdata = DBITS'(hex_q);
            REG_LEDR:  rdata = DBITS'(ledr_q);
            REG_KDATA: rdata = DBITS'(key_deb);
            REG_KCTRL: rdata = stat_word(kstat);
            REG_SDATA: rdata = DBITS'(sw_deb);
            REG_SCTRL: rdata = stat_word(sstat);
            REG_TCNT:  rdata = tcnt_q;
            REG_TLIM:  rdata = tlim_q;
            REG_TCTL:  rdata = stat_word(tstat);
            default:   rdata = '0;
        endcase
    end

    assign bus.rd_data = rdata;
    assign bus.io_hit  = (sel != REG_NONE);
    assign hex         = hex_q;
    assign ledr        = ledr_q;

    assign wr_tcnt = bus.wr_en && (sel == REG_TCNT);
    assign wr_tlim = bus.wr_en && (sel == REG_TLIM);
    assign tick    = (pre_q == PW'(TICKCYCLES - 1));
    // Software writes to the counter or limit override a coincident tick entirely.
    assign t_evt   = tick && (tlim_q != '0) && (tcnt_q == tlim_q - DBITS'(1)) &&
                     !wr_tcnt && !wr_tlim;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_q  <= HEXRESET;
            ledr_q <= '0;
        end else if (bus.wr_en) begin
            if (sel == REG_HEX)
                hex_q <= bus.wr_data[HEXBITS-1:0];
            if (sel == REG_LEDR)
                ledr_q <= bus.wr_data[LEDRBITS-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q  <= '0;
            tcnt_q <= '0;
            tlim_q <= '0;
        end else if (wr_tlim) begin
            tlim_q <= bus.wr_data;
            tcnt_q <= '0;
            pre_q  <= '0;
        end else if (wr_tcnt) begin
            tcnt_q <= bus.wr_data;
            pre_q  <= '0;
        end else begin
            pre_q <= tick ? '0 : pre_q + PW'(1);
            if (tick)
                tcnt_q <= t_evt ? '0 : tcnt_q + DBITS'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kstat <= '0;
            sstat <= '0;
            tstat <= '0;
        end else begin
            kstat <= status_next(kstat, key_change, bus.rd_en && (sel == REG_KDATA),
                                 bus.wr_en && (sel == REG_KCTRL),
                                 bus.wr_data[STAT_READY], bus.wr_data[STAT_OVERRUN]);
            sstat <= status_next(sstat, sw_change, bus.rd_en && (sel == REG_SDATA),
                                 bus.wr_en && (sel == REG_SCTRL),
                                 bus.wr_data[STAT_READY], bus.wr_data[STAT_OVERRUN]);
            tstat <= status_next(tstat, t_evt, 1'b0,
                                 bus.wr_en && (sel == REG_TCTL),
                                 bus.wr_data[STAT_READY], bus.wr_data[STAT_OVERRUN]);
        end
    end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl with short debounce and tick periods; expected values
// are hand-computed edge counts from each stimulus change.
module tb_mmio_ctrl;
    localparam logic [31:0] A_HEX   = 32'hFFFF_F000;
    localparam logic [31:0] A_LEDR  = 32'hFFFF_F020;
    localparam logic [31:0] A_KDATA = 32'hFFFF_F080;
    localparam logic [31:0] A_KCTRL = 32'hFFFF_F084;
    localparam logic [31:0] A_SDATA = 32'hFFFF_F090;
    localparam logic [31:0] A_SCTRL = 32'hFFFF_F094;
    localparam logic [31:0] A_TCNT  = 32'hFFFF_F100;
    localparam logic [31:0] A_TLIM  = 32'hFFFF_F104;
    localparam logic [31:0] A_TCTL  = 32'hFFFF_F108;
    localparam logic [31:0] A_NONE  = 32'hFFFF_F0F0;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key_n = 4'hF;
    logic [9:0] sw    = '0;
    logic [23:0] hex;
    logic [9:0]  ledr;
    int checks   = 0;
    int failures = 0;

    mmio_ctrl_if #(.DBITS(32)) bus ();

    mmio_ctrl #(.DEBCYCLES(4), .TICKCYCLES(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .key_n (key_n),
        .sw    (sw),
        .hex   (hex),
        .ledr  (ledr)
    );

    // Long half-period so several #1-spaced reads fit between edges.
    always #100 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string tag);
        bus.addr  = a;
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        #1;
        chk(tag, bus.rd_data, exp);
    endtask

    task automatic hitchk(input logic [31:0] a, input logic exp, input string tag);
        bus.addr  = a;
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        #1;
        chk(tag, {31'b0, bus.io_hit}, {31'b0, exp});
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.addr    = a;
        bus.wr_data = d;
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b0;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] exp, input string tag);
        bus.addr  = a;
        bus.rd_en = 1'b1;
        bus.wr_en = 1'b0;
        #1;
        chk(tag, bus.rd_data, exp);
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    initial begin
        logic [31:0] amap [9];
        amap = '{A_HEX, A_LEDR, A_KDATA, A_KCTRL, A_SDATA, A_SCTRL, A_TCNT, A_TLIM, A_TCTL};
        bus.addr    = '0;
        bus.rd_en   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        cyc(3);
        reset = 1'b0;

        peek(A_TCNT,  32'h0,        "rst_tcnt");
        peek(A_HEX,   32'h00FEDEAD, "rst_hex");
        peek(A_LEDR,  32'h0,        "rst_ledr");
        peek(A_KDATA, 32'h0,        "rst_kdata");
        peek(A_KCTRL, 32'h0,        "rst_kctrl");
        peek(A_SDATA, 32'h0,        "rst_sdata");
        peek(A_SCTRL, 32'h0,        "rst_sctrl");
        peek(A_TLIM,  32'h0,        "rst_tlim");
        peek(A_TCTL,  32'h0,        "rst_tctl");
        chk("rst_hex_port", {8'h0, hex}, 32'h00FEDEAD);
        chk("rst_ledr_port", {22'h0, ledr}, 32'h0);
        for (int i = 0; i < 9; i++)
            hitchk(amap[i], 1'b1, "hit_mapped");
        hitchk(A_NONE, 1'b0, "hit_unmapped");
        peek(A_NONE, 32'h0, "rd_unmapped");

        // Key press: 2 sync + 4 debounce edges.
        key_n = 4'b1110;
        cyc(5);
        peek(A_KDATA, 32'h0, "key_before_latency");
        cyc(1);
        peek(A_KDATA, 32'h1, "key_after_latency");
        peek(A_KCTRL, 32'h1, "kctrl_ready");
        load(A_KDATA, 32'h1, "kdata_load");
        peek(A_KCTRL, 32'h0, "kctrl_read_clear");

        key_n = 4'hF;
        cyc(6);
        peek(A_KDATA, 32'h0, "key_release");
        peek(A_KCTRL, 32'h1, "kctrl_release_ready");

        // Read-clear landing on the same edge as a new event: ready stays, no overrun.
        key_n = 4'hE;
        cyc(5);
        load(A_KDATA, 32'h0, "kdata_old_value");
        peek(A_KDATA, 32'h1, "key_repress");
        peek(A_KCTRL, 32'h1, "kctrl_rdclr_vs_event");

        // Switch glitch shorter than the debounce window.
        sw = 10'h001;
        cyc(3);
        sw = 10'h000;
        cyc(6);
        peek(A_SDATA, 32'h0, "sw_glitch_ignored");
        peek(A_SCTRL, 32'h0, "sctrl_glitch");
        sw = 10'h3FF;
        cyc(6);
        peek(A_SDATA, 32'h3FF, "sw_all_on");
        peek(A_SCTRL, 32'h1,   "sctrl_ready");
        sw = 10'h000;
        cyc(6);
        peek(A_SDATA, 32'h0, "sw_all_off");
        peek(A_SCTRL, 32'h5, "sctrl_overrun");
        store(A_SCTRL, 32'h5);
        peek(A_SCTRL, 32'h5, "sctrl_write_ones");
        store(A_SCTRL, 32'h0);
        peek(A_SCTRL, 32'h0, "sctrl_write_zero");

        // Timer: limit 3, tick every 3 edges.
        store(A_TLIM, 32'd3);
        peek(A_TCNT, 32'd0, "tcnt_after_tlim");
        peek(A_TLIM, 32'd3, "tlim_readback");
        cyc(3);
        peek(A_TCNT, 32'd1, "tcnt_tick1");
        cyc(3);
        peek(A_TCNT, 32'd2, "tcnt_tick2");
        cyc(3);
        peek(A_TCNT, 32'd0, "tcnt_wrap1");
        peek(A_TCTL, 32'h1, "tctl_first_wrap");
        cyc(3);
        peek(A_TCNT, 32'd1, "tcnt_tick4");
        cyc(3);
        peek(A_TCNT, 32'd2, "tcnt_tick5");
        cyc(3);
        peek(A_TCNT, 32'd0, "tcnt_wrap2");
        peek(A_TCTL, 32'h5, "tctl_second_wrap");
        store(A_TCTL, 32'h0);
        peek(A_TCTL, 32'h0, "tctl_cleared");
        cyc(7);
        peek(A_TCNT, 32'd2, "tcnt_before_wrap");
        store(A_TCNT, 32'd1);
        peek(A_TCNT, 32'd1, "tcnt_write_vs_tick");
        peek(A_TCTL, 32'h0, "tctl_no_event_on_write");
        cyc(3);
        peek(A_TCNT, 32'd2, "tcnt_after_write_tick");

        // Store and same-cycle load of LEDR.
        bus.addr    = A_LEDR;
        bus.wr_data = 32'h1234_5678;
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b1;
        #1;
        chk("ledr_same_cycle_old", bus.rd_data, 32'h0);
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        chk("ledr_port", {22'h0, ledr}, 32'h278);
        peek(A_LEDR, 32'h278, "ledr_readback");
        store(A_HEX, 32'hFF12_3456);
        chk("hex_port", {8'h0, hex}, 32'h0012_3456);
        peek(A_HEX, 32'h0012_3456, "hex_readback");
        store(A_KDATA, 32'h0);
        peek(A_KDATA, 32'h1, "kdata_read_only");

        // Reset while switches are mid-debounce and the timer is running.
        sw = 10'h155;
        cyc(4);
        reset = 1'b1;
        #1;
        chk("mid_rst_hex_port", {8'h0, hex}, 32'h00FEDEAD);
        chk("mid_rst_ledr_port", {22'h0, ledr}, 32'h0);
        peek(A_SDATA, 32'h0, "mid_rst_sdata");
        peek(A_KDATA, 32'h0, "mid_rst_kdata");
        peek(A_KCTRL, 32'h0, "mid_rst_kctrl");
        peek(A_TLIM,  32'h0, "mid_rst_tlim");
        peek(A_TCNT,  32'h0, "mid_rst_tcnt");
        cyc(1);
        reset = 1'b0;
        cyc(5);
        peek(A_SDATA, 32'h0, "post_rst_sdata_early");
        peek(A_KDATA, 32'h0, "post_rst_kdata_early");
        cyc(1);
        peek(A_SDATA, 32'h155, "post_rst_sdata");
        peek(A_KDATA, 32'h1,   "post_rst_kdata");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
